// File: rtl/class_hvec_pkg.sv
// Shared definitions for the class hypervector store.
//   CLASS_HVEC_INIT : reset/constant contents, 8 classes x 3 frames x 64 bits
//   state_t         : streaming FSM state encoding
//   class_w/frame_w : index widths derived from the class/frame counts
//   init_word       : table lookup that stays defined for any parameterisation
package class_hvec_pkg;

  localparam int INIT_CLASSES = 8;
  localparam int INIT_FRAMES  = 3;
  localparam int INIT_W       = 64;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } state_t;

  typedef logic [INIT_W-1:0] hvec_init_t [INIT_CLASSES][INIT_FRAMES];

  localparam hvec_init_t CLASS_HVEC_INIT = '{
    '{64'hC8E2CE31A456C2ED, 64'h5D13B7A0E94F2861, 64'h0F7A4C9D36E2B158},
    '{64'h7E39D4A1C05B826F, 64'hA2C6F81D4937E0B5, 64'h3B90E5727DA14C6E},
    '{64'h91D4A63F08B7E25C, 64'h4E7B2C91D56A03F8, 64'hD0385E6BA91C74F2},
    '{64'h26AF93C47E0D5B18, 64'hB85E01D2C37A946F, 64'h6C17F4A8902BE3D5},
    '{64'h3905338C76652C45, 64'hE4A72B6D15C9F830, 64'h57C1D09E3B46A82F},
    '{64'hAB62F3057D8E91C4, 64'h1D9C47B2E06A35F8, 64'hF3084AD6C51B7E29},
    '{64'h62E5B91C0A4D378F, 64'hC79F26E35B810D4A, 64'h08B4D7F1A29C6E53},
    '{64'h9F3C5A806ED172B4, 64'h35D86E0CB4A71F92, 64'hE6127B49D83F05AC}
  };

  // A count of one still needs a one-bit index.
  function automatic int class_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int frame_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Entries beyond the stored table (larger parameterisations) get a
  // deterministic index-derived pattern so the storage is always defined.
  function automatic logic [INIT_W-1:0] init_word(int c, int f);
    if (c >= 0 && c < INIT_CLASSES && f >= 0 && f < INIT_FRAMES)
      return CLASS_HVEC_INIT[c][f];
    return {32'(c), 32'(f)} ^ 64'h9E3779B97F4A7C15;
  endfunction

endpackage

// File: rtl/class_hvec_mem.sv
// Class hypervector storage: one combinational read port, one write port.
// Build option CLASS_HVEC_WRITE_EN:
//   defined   - register array, loaded from CLASS_HVEC_INIT by rst, writable
//   undefined - constant table; clk/rst/wr_* ports are not present
// Ports:
//   clk, rst                          clock / async active-high reset (write build)
//   wr_en, wr_class, wr_frame, wr_data write port; out-of-range indices ignored
//   rd_class, rd_frame -> rd_data     read port; out-of-range reads return 0
module class_hvec_mem
  import class_hvec_pkg::*;
#(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int NUM_CLASSES        = 8,
  parameter int FRAMES_PER_CLASS   = 3,
  localparam int CLASS_W = class_w(NUM_CLASSES),
  localparam int FRAME_W = frame_w(FRAMES_PER_CLASS)
) (
`ifdef CLASS_HVEC_WRITE_EN
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [CLASS_W-1:0]            wr_class,
  input  logic [FRAME_W-1:0]            wr_frame,
  input  logic [DI_PARALLEL_W_BITS-1:0] wr_data,
`endif
  input  logic [CLASS_W-1:0]            rd_class,
  input  logic [FRAME_W-1:0]            rd_frame,
  output logic [DI_PARALLEL_W_BITS-1:0] rd_data
);

  logic rd_ok;
  assign rd_ok = (int'(rd_class) < NUM_CLASSES) && (int'(rd_frame) < FRAMES_PER_CLASS);

`ifdef CLASS_HVEC_WRITE_EN
  logic [DI_PARALLEL_W_BITS-1:0] mem_q [NUM_CLASSES][FRAMES_PER_CLASS];
  logic                          wr_ok;

  assign wr_ok = wr_en && (int'(wr_class) < NUM_CLASSES) && (int'(wr_frame) < FRAMES_PER_CLASS);

  // NOTE: this array is reset on purpose -- rst must restore the known class
  // vectors, so it maps to flops rather than a RAM macro that cannot be reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CLASSES; c++)
        for (int f = 0; f < FRAMES_PER_CLASS; f++)
          mem_q[c][f] <= DI_PARALLEL_W_BITS'(init_word(c, f));
    end else if (wr_ok) begin
      mem_q[wr_class][wr_frame] <= wr_data;
    end
  end

  // Combinational read of the current contents gives read-before-write
  // when the same entry is written and loaded on one edge.
  assign rd_data = rd_ok ? mem_q[rd_class][rd_frame] : '0;
`else
  assign rd_data = rd_ok ? DI_PARALLEL_W_BITS'(init_word(int'(rd_class), int'(rd_frame))) : '0;
`endif

endmodule

// File: rtl/class_hvec_store.sv
// Class hypervector store: on request, streams the FRAMES_PER_CLASS frames of
// one class vector over a valid/ready output, one frame per handshake with no
// bubbles. Build option CLASS_HVEC_WRITE_EN adds the wr_* frame write port.
// Ports:
//   clk, rst                         clock / async active-high reset
//   req_valid, req_ready, req_class  stream request (accepted only in IDLE)
//   req_err                          one-cycle pulse: out-of-range class accepted
//   out_valid, out_ready, out_data   frame output handshake
//   out_class, out_frame, out_last   tag of the frame on out_data
//   wr_en, wr_class, wr_frame, wr_data  frame write (CLASS_HVEC_WRITE_EN only)
module class_hvec_store
  import class_hvec_pkg::*;
#(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int NUM_CLASSES        = 8,
  parameter int FRAMES_PER_CLASS   = 3,
  localparam int CLASS_W = class_w(NUM_CLASSES),
  localparam int FRAME_W = frame_w(FRAMES_PER_CLASS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [CLASS_W-1:0]            req_class,
  output logic                          req_err,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DI_PARALLEL_W_BITS-1:0] out_data,
  output logic [CLASS_W-1:0]            out_class,
  output logic [FRAME_W-1:0]            out_frame,
  output logic                          out_last
`ifdef CLASS_HVEC_WRITE_EN
  ,
  input  logic                          wr_en,
  input  logic [CLASS_W-1:0]            wr_class,
  input  logic [FRAME_W-1:0]            wr_frame,
  input  logic [DI_PARALLEL_W_BITS-1:0] wr_data
`endif
);

  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES_PER_CLASS - 1);

  state_t                        state_q, state_d;
  logic [CLASS_W-1:0]            cls_q;
  logic [FRAME_W-1:0]            frame_q;
  logic [DI_PARALLEL_W_BITS-1:0] data_q;
  logic                          last_q;
  logic                          err_q;

  logic [CLASS_W-1:0]            rd_class;
  logic [FRAME_W-1:0]            rd_frame;
  logic [DI_PARALLEL_W_BITS-1:0] rd_data;

  logic req_in_range, accept, load_first, advance, load_next;

  assign req_in_range = int'(req_class) < NUM_CLASSES;
  assign accept       = (state_q == ST_IDLE) && req_valid;
  assign load_first   = accept && req_in_range;
  assign advance      = (state_q == ST_STREAM) && out_ready;
  assign load_next    = advance && !last_q;

  // The read port always addresses the frame that the next load would take:
  // frame 0 of the requested class in IDLE, the following frame in STREAM.
  assign rd_class = (state_q == ST_STREAM) ? cls_q : req_class;
  assign rd_frame = (state_q == ST_STREAM) ? frame_q + FRAME_W'(1) : '0;

  class_hvec_mem #(
    .DI_PARALLEL_W_BITS (DI_PARALLEL_W_BITS),
    .NUM_CLASSES        (NUM_CLASSES),
    .FRAMES_PER_CLASS   (FRAMES_PER_CLASS)
  ) u_mem (
`ifdef CLASS_HVEC_WRITE_EN
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_class (wr_class),
    .wr_frame (wr_frame),
    .wr_data  (wr_data),
`endif
    .rd_class (rd_class),
    .rd_frame (rd_frame),
    .rd_data  (rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (load_first)         state_d = ST_STREAM;
      ST_STREAM: if (advance && last_q)  state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // Output register: holds the frame on out_data until it is handshaken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_q   <= '0;
      frame_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && !req_in_range;
      if (load_first) begin
        cls_q   <= req_class;
        frame_q <= '0;
        data_q  <= rd_data;
        last_q  <= (LAST_FRAME == '0);
      end else if (load_next) begin
        frame_q <= rd_frame;
        data_q  <= rd_data;
        last_q  <= (rd_frame == LAST_FRAME);
      end
    end
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    out_valid = (state_q == ST_STREAM);
  end

  assign req_err   = err_q;
  assign out_data  = data_q;
  assign out_class = cls_q;
  assign out_frame = frame_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_class_hvec_store.sv
// Directed bench for class_hvec_store. Expected frames are pushed to a
// scoreboard when a request is driven and popped on each output handshake.
// A second, 5-class instance exercises out-of-range requests, since a 3-bit
// class index cannot express an out-of-range value when NUM_CLASSES is 8.
module tb_class_hvec_store;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_err;
  logic [2:0]  req_class;
  logic        out_valid, out_ready, out_last;
  logic [63:0] out_data;
  logic [2:0]  out_class;
  logic [1:0]  out_frame;

  logic        e_req_valid, e_req_ready, e_req_err;
  logic [2:0]  e_req_class;
  logic        e_out_valid, e_out_ready, e_out_last;
  logic [63:0] e_out_data;
  logic [2:0]  e_out_class;
  logic [1:0]  e_out_frame;

`ifdef CLASS_HVEC_WRITE_EN
  logic        wr_en;
  logic [2:0]  wr_class;
  logic [1:0]  wr_frame;
  logic [63:0] wr_data;
`endif

  int checks   = 0;
  int failures = 0;

  logic [63:0] tbl [8][3] = '{
    '{64'hC8E2CE31A456C2ED, 64'h5D13B7A0E94F2861, 64'h0F7A4C9D36E2B158},
    '{64'h7E39D4A1C05B826F, 64'hA2C6F81D4937E0B5, 64'h3B90E5727DA14C6E},
    '{64'h91D4A63F08B7E25C, 64'h4E7B2C91D56A03F8, 64'hD0385E6BA91C74F2},
    '{64'h26AF93C47E0D5B18, 64'hB85E01D2C37A946F, 64'h6C17F4A8902BE3D5},
    '{64'h3905338C76652C45, 64'hE4A72B6D15C9F830, 64'h57C1D09E3B46A82F},
    '{64'hAB62F3057D8E91C4, 64'h1D9C47B2E06A35F8, 64'hF3084AD6C51B7E29},
    '{64'h62E5B91C0A4D378F, 64'hC79F26E35B810D4A, 64'h08B4D7F1A29C6E53},
    '{64'h9F3C5A806ED172B4, 64'h35D86E0CB4A71F92, 64'hE6127B49D83F05AC}
  };

  typedef struct {
    logic [63:0] data;
    logic [2:0]  cls;
    logic [1:0]  frame;
    logic        last;
  } exp_t;

  exp_t sb [$];

  class_hvec_store dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_class (req_class),
    .req_err   (req_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_class (out_class),
    .out_frame (out_frame),
    .out_last  (out_last)
`ifdef CLASS_HVEC_WRITE_EN
    ,
    .wr_en     (wr_en),
    .wr_class  (wr_class),
    .wr_frame  (wr_frame),
    .wr_data   (wr_data)
`endif
  );

  class_hvec_store #(.NUM_CLASSES(5)) dut_err (
    .clk       (clk),
    .rst       (rst),
    .req_valid (e_req_valid),
    .req_ready (e_req_ready),
    .req_class (e_req_class),
    .req_err   (e_req_err),
    .out_valid (e_out_valid),
    .out_ready (e_out_ready),
    .out_data  (e_out_data),
    .out_class (e_out_class),
    .out_frame (e_out_frame),
    .out_last  (e_out_last)
`ifdef CLASS_HVEC_WRITE_EN
    ,
    .wr_en     (1'b0),
    .wr_class  (3'd0),
    .wr_frame  (2'd0),
    .wr_data   (64'd0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_stream(input int c);
    exp_t e;
    for (int f = 0; f < 3; f++) begin
      e.data  = tbl[c][f];
      e.cls   = 3'(c);
      e.frame = 2'(f);
      e.last  = (f == 2);
      sb.push_back(e);
    end
  endtask

  // Drive inputs for one cycle; if a handshake happens at the coming edge,
  // compare the frame on the outputs against the scoreboard head.
  task automatic step(input logic v, input logic [2:0] c, input logic rdy);
    exp_t e;
    req_valid = v;
    req_class = c;
    out_ready = rdy;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_frame", out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("frame_data",  out_data,  e.data);
        check("frame_class", out_class, e.cls);
        check("frame_index", out_frame, e.frame);
        check("frame_last",  out_last,  e.last);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    req_valid = 1'b0; req_class = '0; out_ready = 1'b0;
    e_req_valid = 1'b0; e_req_class = '0; e_out_ready = 1'b0;
`ifdef CLASS_HVEC_WRITE_EN
    wr_en = 1'b0; wr_class = '0; wr_frame = '0; wr_data = '0;
`endif
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_req_err",   req_err,   1'b0);
    check("rst_out_data",  out_data,  64'd0);
    check("rst_out_class", out_class, 3'd0);
    check("rst_out_frame", out_frame, 2'd0);
    check("rst_out_last",  out_last,  1'b0);

    // Class 0, accepted on the first edge after reset release, no stalls
    rst = 1'b0;
    push_stream(0);
    step(1'b1, 3'd0, 1'b1);
    check("first_latency_valid", out_valid, 1'b1);
    check("first_frame_data",    out_data,  64'hC8E2CE31A456C2ED);
    for (int i = 0; i < 3; i++) begin
      check("zero_bubble_valid", out_valid, 1'b1);
      step(1'b0, 3'd0, 1'b1);
    end
    check("idle_after_last_valid", out_valid, 1'b0);
    check("idle_after_last_ready", req_ready, 1'b1);
    check("sb_drained_c0", 64'(sb.size()), 64'd0);

    // Class 4, ready pattern 1,0,0,1 with a competing request held in STREAM
    push_stream(4);
    step(1'b1, 3'd4, 1'b1);
    check("stall_ready_low", req_ready, 1'b0);
    check("stall_data_a", out_data, 64'h3905338C76652C45);
    step(1'b1, 3'd3, 1'b0);
    check("stall_data_b",  out_data,  64'h3905338C76652C45);
    check("stall_frame_b", out_frame, 2'd0);
    step(1'b1, 3'd3, 1'b0);
    check("stall_data_c",  out_data,  64'h3905338C76652C45);
    check("stall_valid_c", out_valid, 1'b1);
    step(1'b0, 3'd0, 1'b1);
    step(1'b0, 3'd0, 1'b1);
    step(1'b0, 3'd0, 1'b1);
    check("c4_done_valid", out_valid, 1'b0);
    check("sb_drained_c4", 64'(sb.size()), 64'd0);

    // Highest class
    push_stream(7);
    step(1'b1, 3'd7, 1'b1);
    repeat (3) step(1'b0, 3'd0, 1'b1);
    check("sb_drained_c7", 64'(sb.size()), 64'd0);

    // Out-of-range classes on the 5-class instance, then a valid request
    for (int k = 0; k < 2; k++) begin
      e_req_valid = 1'b1;
      e_req_class = (k == 0) ? 3'd5 : 3'd7;
      @(negedge clk);
      check("err_pulse",     e_req_err,   1'b1);
      check("err_no_valid",  e_out_valid, 1'b0);
      check("err_ready",     e_req_ready, 1'b1);
      e_req_valid = 1'b0;
      @(negedge clk);
      check("err_one_cycle", e_req_err,   1'b0);
      check("err_no_valid2", e_out_valid, 1'b0);
    end
    e_req_valid = 1'b1; e_req_class = 3'd4; e_out_ready = 1'b1;
    @(negedge clk);
    e_req_valid = 1'b0;
    check("err_next_valid", e_out_valid, 1'b1);
    check("err_next_data",  e_out_data,  tbl[4][0]);
    check("err_next_class", e_out_class, 3'd4);
    repeat (3) @(negedge clk);
    check("err_next_done",  e_out_valid, 1'b0);

`ifdef CLASS_HVEC_WRITE_EN
    // Write [2][0] on the accepting edge: frame 0 loads the old value
    push_stream(2);
    wr_en = 1'b1; wr_class = 3'd2; wr_frame = 2'd0; wr_data = 64'hAAAA5555AAAA5555;
    step(1'b1, 3'd2, 1'b0);
    check("rbw_frame0", out_data, tbl[2][0]);
    // Write [2][1] while frame 0 is stalled
    wr_frame = 2'd1; wr_data = 64'hFFFF0000FFFF0000;
    step(1'b0, 3'd0, 1'b0);
    check("wr_hold_frame0", out_data, tbl[2][0]);
    e = sb[1]; e.data = 64'hFFFF0000FFFF0000; sb[1] = e;
    // Out-of-range frame index is ignored
    wr_frame = 2'd3; wr_data = 64'd0;
    step(1'b0, 3'd0, 1'b0);
    wr_en = 1'b0;
    check("wr_oob_frame0", out_data, tbl[2][0]);
    repeat (3) step(1'b0, 3'd0, 1'b1);
    check("sb_drained_wr", 64'(sb.size()), 64'd0);
`endif

    // Reset during frame 1 of a class 5 stream
    push_stream(5);
    step(1'b1, 3'd5, 1'b1);
    step(1'b0, 3'd0, 1'b1);
    check("pre_rst_frame", out_frame, 2'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_ready", req_ready, 1'b1);
    check("mid_rst_data",  out_data,  64'd0);
    check("mid_rst_frame", out_frame, 2'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) step(1'b0, 3'd0, 1'b1);
    check("post_rst_valid", out_valid, 1'b0);

    // Storage back to its initial contents after reset
    push_stream(2);
    step(1'b1, 3'd2, 1'b1);
    repeat (3) step(1'b0, 3'd0, 1'b1);
    check("sb_drained_final", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
